punc_datapath_gen: RTL and testbench
====================================

PUNC_DATAPATH_GEN -- requirements
Module: punc_datapath_gen

Interface
REQ-001 Parameter WIDTH, 16, data/register/PC width in bits (>=8).
REQ-002 Parameter NREGS, 8, register count (power of two, >=2); RW = log2(NREGS).
REQ-003 Parameter ADDR_W, 16, memory address width (<=WIDTH).
REQ-004 Parameter RESET_PC, 0, PC value after reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cmd_valid in 1 / cmd_ready out 1  command handshake; accepted when both high.
REQ-008 cmd_op in 3  0 FETCH, 1 ALU, 2 LD, 3 ST, 4 LDI, 5 STI, 6 BR, 7 JMP.
REQ-009 cmd_fn in 3  ALU: [1:0] fn (0 PASS, 1 ADD, 2 AND, 3 NOT), [2] use_imm; BR: nzp mask; JMP: [0] link.
REQ-010 cmd_dst, cmd_sa, cmd_sb in RW each; cmd_imm in WIDTH (pre-sign-extended).
REQ-011 done out 1  one-cycle pulse on command completion; err out 1  one-cycle pulse on illegal command.
REQ-012 mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out WIDTH, mem_ack in 1, mem_rdata in WIDTH  variable-latency memory port.
REQ-013 ir out WIDTH, cc out 3 {N,Z,P}, pc_dbg out WIDTH, rf_dbg_addr in RW, rf_dbg_data out WIDTH (combinational read).

Function
REQ-014 FSM states IDLE, REQ1, REQ2, DONE; cmd_ready high only in IDLE.
REQ-015 ALU/BR/JMP: architectural update at accepting edge; IDLE->DONE; done high next cycle; DONE->IDLE.
REQ-016 ALU: R[dst] <= fn(R[sa], use_imm ? imm : R[sb]); sums wrap mod 2^WIDTH.
REQ-017 BR: PC <= PC+imm iff (mask & cc) != 0; else PC unchanged; still completes with done.
REQ-018 JMP: PC <= R[sa]; if link, R[NREGS-1] <= old PC; link with sa==NREGS-1 jumps to old register value.
REQ-019 Memory ops: IDLE->REQ1; mem_addr = low ADDR_W bits of (FETCH ? PC : PC+imm); mem_req held with stable addr/we/wdata until mem_ack sampled high.
REQ-020 mem_ack ignored in cycle req first asserts? No: ack valid any cycle mem_req is high; mem_rdata valid in ack cycle; mem_req low the cycle after ack.
REQ-021 FETCH: at ack edge IR <= rdata, PC <= PC+1 (all-ones wraps to 0).
REQ-022 LD: at ack edge R[dst] <= rdata; ST: mem_we=1, wdata=R[sb] sampled at acceptance.
REQ-023 LDI/STI: first access reads pointer; at ack, pointer latched, REQ1->REQ2; second access uses low ADDR_W bits of pointer, read to R[dst] (LDI) or write R[sb] (STI).
REQ-024 Last ack edge -> DONE; done high following cycle; ST/STI done only after write ack.
REQ-025 CC on every R write by ALU/LD/LDI: N=msb, Z=value==0, P otherwise; exactly one bit set; link writes do not touch CC.
REQ-026 cmd_valid while cmd_ready low has no effect; mem_ack in IDLE/DONE ignored.

Reset
REQ-027 Reset: PC=RESET_PC, IR=0, all R=0, cc=3'b010, state IDLE, mem_req=0, mem_we=0, done=0, err=0.
REQ-028 Reset mid-access drops mem_req next edge; outstanding transaction abandoned, late ack ignored.

Configuration
REQ-029 Macro PUNC_DP_INDIRECT_EN defined: LDI/STI as REQ-023.
REQ-030 Undefined: LDI/STI accepted, no state or memory change, no mem_req, err pulses next cycle instead of done; REQ2 absent.

Verification
REQ-031 Reset, FETCH, ack after 3 cycles rdata=16'h1234 -> ir=16'h1234, pc_dbg=1, done one cycle after ack.
REQ-032 R1=5, ALU ADD imm=-5 into R2 -> R2=0, cc=3'b010, done at cycle N+1.
REQ-033 PC=10, LDI imm=2: mem[12]=40, mem[40]=16'h8001 -> addresses 12 then 40, R[dst]=16'h8001, cc=3'b100.
REQ-034 cc=3'b001, BR mask 3'b110 imm=4 -> PC unchanged; mask 3'b001 -> PC+4.
REQ-035 PC=16'hFFFF FETCH -> PC=0; rst during REQ1 with ack delayed -> mem_req low next cycle, later ack no effect.
REQ-036 Macro undefined: STI -> err pulse, no mem_req, memory unchanged.

Source files
------------

// File: rtl/punc_datapath_gen.sv
// punc_datapath_gen: small accumulator-less datapath sequencer with register
// file, PC, IR and condition codes, driven by a command handshake and a
// variable-latency memory port.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_op, cmd_fn               operation and function/mask/link field
//   cmd_dst, cmd_sa, cmd_sb      register selects
//   cmd_imm                      pre-sign-extended immediate
//   done, err                    one-cycle completion / illegal-command pulses
//   mem_req/we/addr/wdata        memory request, held until mem_ack
//   mem_ack, mem_rdata           memory response (rdata valid with ack)
//   ir, cc, pc_dbg               architectural state observation
//   rf_dbg_addr/rf_dbg_data      combinational register file read port
//
// Build option: define PUNC_DP_INDIRECT_EN to enable LDI/STI (pointer
// indirection via a second memory access). Without it LDI/STI complete
// with an err pulse and no side effects.
module punc_datapath_gen #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int RW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_fn,
  input  logic [RW-1:0]     cmd_dst,
  input  logic [RW-1:0]     cmd_sa,
  input  logic [RW-1:0]     cmd_sb,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  ir,
  output logic [2:0]        cc,
  output logic [WIDTH-1:0]  pc_dbg,
  input  logic [RW-1:0]     rf_dbg_addr,
  output logic [WIDTH-1:0]  rf_dbg_data
);

  localparam logic [2:0] OP_FETCH = 3'd0, OP_ALU = 3'd1, OP_LD  = 3'd2, OP_ST  = 3'd3,
                         OP_LDI   = 3'd4, OP_STI = 3'd5, OP_BR  = 3'd6, OP_JMP = 3'd7;

`ifdef PUNC_DP_INDIRECT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ1 = 2'd1, REQ2 = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ1 = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t state, state_n;

  logic [WIDTH-1:0]  rf [NREGS];
  logic [WIDTH-1:0]  pc;
  logic [ADDR_W-1:0] addr_r;
  logic [WIDTH-1:0]  wdata_r;
  logic              we_r;
  logic [2:0]        op_r;
  logic [RW-1:0]     dst_r;
  logic              bad_r;    // current DONE visit reports err instead of done

  logic              accept;
  logic [WIDTH-1:0]  rf_sa, opb, alu_res, ea;
  logic [ADDR_W-1:0] addr_n;
  logic              is_mem, is_ind;

  function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])  return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  assign cmd_ready   = (state == IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign rf_dbg_data = rf[rf_dbg_addr];
  assign pc_dbg      = pc;
  assign rf_sa       = rf[cmd_sa];
  assign ea          = pc + cmd_imm;
  assign addr_n      = (cmd_op == OP_FETCH) ? pc[ADDR_W-1:0] : ea[ADDR_W-1:0];
  assign is_ind      = (cmd_op == OP_LDI) | (cmd_op == OP_STI);
  assign is_mem      = (cmd_op == OP_FETCH) | (cmd_op == OP_LD) | (cmd_op == OP_ST);

  // PASS forwards operand B so that use_imm gives a load-immediate.
  always_comb begin
    opb     = cmd_fn[2] ? cmd_imm : rf[cmd_sb];
    alu_res = opb;
    case (cmd_fn[1:0])
      2'd0:    alu_res = opb;
      2'd1:    alu_res = rf_sa + opb;
      2'd2:    alu_res = rf_sa & opb;
      default: alu_res = ~rf_sa;
    endcase
  end

`ifdef PUNC_DP_INDIRECT_EN
  assign mem_req = (state == REQ1) | (state == REQ2);
`else
  assign mem_req = (state == REQ1);
`endif
  assign mem_we    = mem_req & we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign done      = (state == DONE) & ~bad_r;
  assign err       = (state == DONE) &  bad_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) begin
`ifdef PUNC_DP_INDIRECT_EN
        state_n = (is_mem | is_ind) ? REQ1 : DONE;
`else
        state_n = is_mem ? REQ1 : DONE;
`endif
      end
      REQ1: if (mem_ack) begin
`ifdef PUNC_DP_INDIRECT_EN
        state_n = (op_r == OP_LDI || op_r == OP_STI) ? REQ2 : DONE;
`else
        state_n = DONE;
`endif
      end
`ifdef PUNC_DP_INDIRECT_EN
      REQ2: if (mem_ack) state_n = DONE;
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      cc      <= 3'b010;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      we_r    <= 1'b0;
      op_r    <= OP_FETCH;
      dst_r   <= '0;
      bad_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r    <= cmd_op;
          dst_r   <= cmd_dst;
          addr_r  <= addr_n;
          wdata_r <= rf[cmd_sb];       // store data frozen at acceptance
          we_r    <= (cmd_op == OP_ST); // STI's pointer read is a read
          bad_r   <= 1'b0;
          case (cmd_op)
            OP_ALU: begin
              rf[cmd_dst] <= alu_res;
              cc          <= cc_of(alu_res);
            end
            OP_BR:  if ((cmd_fn & cc) != 3'b000) pc <= ea;
            OP_JMP: begin
              // rf_sa is read before the link write lands, so sa==NREGS-1
              // jumps to the old register value.
              pc <= rf_sa;
              if (cmd_fn[0]) rf[NREGS-1] <= pc;
            end
`ifndef PUNC_DP_INDIRECT_EN
            OP_LDI, OP_STI: bad_r <= 1'b1;
`endif
            default: ;
          endcase
        end
        REQ1: if (mem_ack) begin
          case (op_r)
            OP_FETCH: begin
              ir <= mem_rdata;
              pc <= pc + 1'b1;
            end
            OP_LD: begin
              rf[dst_r] <= mem_rdata;
              cc        <= cc_of(mem_rdata);
            end
`ifdef PUNC_DP_INDIRECT_EN
            OP_LDI, OP_STI: begin
              addr_r <= mem_rdata[ADDR_W-1:0];
              we_r   <= (op_r == OP_STI);
            end
`endif
            default: ;
          endcase
        end
`ifdef PUNC_DP_INDIRECT_EN
        REQ2: if (mem_ack && op_r == OP_LDI) begin
          rf[dst_r] <= mem_rdata;
          cc        <= cc_of(mem_rdata);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_datapath_gen.sv
// Self-checking bench for punc_datapath_gen (default parameters). Drives
// commands and answers memory requests from one initial block, compares
// every observable against an instruction-level model of the datapath.
module tb_punc_datapath_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0, cmd_fn = '0;
  logic [2:0]  cmd_dst = '0, cmd_sa = '0, cmd_sb = '0;
  logic [15:0] cmd_imm = '0;
  logic        done, err;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir, pc_dbg, rf_dbg_data;
  logic [2:0]  cc;
  logic [2:0]  rf_dbg_addr = '0;

  punc_datapath_gen dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fn(cmd_fn), .cmd_dst(cmd_dst), .cmd_sa(cmd_sa),
    .cmd_sb(cmd_sb), .cmd_imm(cmd_imm),
    .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .cc(cc), .pc_dbg(pc_dbg),
    .rf_dbg_addr(rf_dbg_addr), .rf_dbg_data(rf_dbg_data)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  logic [15:0] ref_r [8];
  logic [15:0] ref_pc, ref_ir;
  logic [2:0]  ref_cc;
  logic [15:0] mem [logic [15:0]];

`ifdef PUNC_DP_INDIRECT_EN
  localparam bit IND = 1'b1;
`else
  localparam bit IND = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] memrd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [2:0] flags(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic wr(input logic [2:0] d, input logic [15:0] v);
    ref_r[d] = v;
    ref_cc   = flags(v);
  endtask

  task automatic model_reset();
    ref_pc = 16'd0; ref_ir = 16'd0; ref_cc = 3'b010;
    for (int i = 0; i < 8; i++) ref_r[i] = 16'd0;
  endtask

  task automatic check_state();
    chk("pc", pc_dbg, ref_pc);
    chk("ir", ir, ref_ir);
    chk("cc", cc, ref_cc);
    for (int i = 0; i < 8; i++) begin
      rf_dbg_addr = 3'(i);
      #1;
      chk($sformatf("rf%0d", i), rf_dbg_data, ref_r[i]);
    end
  endtask

  // Serve one memory access; called on the first negedge with mem_req expected high.
  task automatic mem_access(input logic [15:0] a, input logic we, input logic [15:0] wd,
                            input int lat, output logic [15:0] rd);
    rd = memrd(a);
    for (int c = 0; c <= lat; c++) begin
      chk("mem_req", mem_req, 1);
      chk("mem_addr", mem_addr, a);
      chk("mem_we", mem_we, we);
      if (we) chk("mem_wdata", mem_wdata, wd);
      chk("done_early", done, 0);
      cmd_valid = 1'($urandom_range(0, 1));
      mem_ack   = (c == lat);
      mem_rdata = (c == lat && !we) ? rd : 16'($urandom);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    if (we) mem[a] = wd;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [2:0] fn, input logic [2:0] dst,
                        input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] imm,
                        input int lat);
    logic [15:0] ea, p, rd, b, res, t;
    bit illegal;
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_fn = fn; cmd_dst = dst;
    cmd_sa = sa; cmd_sb = sb; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_fn = 3'($urandom); cmd_dst = 3'($urandom);
    cmd_sa = 3'($urandom); cmd_sb = 3'($urandom); cmd_imm = 16'($urandom);
    ea = ref_pc + imm;
    illegal = !IND && (op == 3'd4 || op == 3'd5);
    case (op)
      3'd0: begin mem_access(ref_pc, 0, 0, lat, rd); ref_ir = rd; ref_pc = ref_pc + 16'd1; end
      3'd1: begin
        b = fn[2] ? imm : ref_r[sb];
        case (fn[1:0])
          2'd0: res = b;
          2'd1: res = 16'((32'(ref_r[sa]) + 32'(b)) % 32'h10000);
          2'd2: res = ref_r[sa] & b;
          default: res = ~ref_r[sa];
        endcase
        wr(dst, res);
      end
      3'd2: begin mem_access(ea, 0, 0, lat, rd); wr(dst, rd); end
      3'd3: mem_access(ea, 1, ref_r[sb], lat, rd);
      3'd4: if (IND) begin
        mem_access(ea, 0, 0, lat, p); mem_access(p, 0, 0, (lat + 1) % 4, rd); wr(dst, rd);
      end
      3'd5: if (IND) begin
        mem_access(ea, 0, 0, lat, p); mem_access(p, 1, ref_r[sb], (lat + 2) % 4, rd);
      end
      3'd6: if ((fn & ref_cc) != 3'b000) ref_pc = ea;
      default: begin
        t = ref_r[sa];
        if (fn[0]) ref_r[7] = ref_pc;
        ref_pc = t;
      end
    endcase
    // completion cycle
    chk("done", done, !illegal);
    chk("err", err, illegal);
    chk("mem_req_after", mem_req, 0);
    cmd_valid = 1'($urandom_range(0, 1));
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    @(negedge clk);
    cmd_valid = 1'b0;
    mem_ack   = 1'b0;
    chk("done_pulse", done, 0);
    chk("err_pulse", err, 0);
    check_state();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    check_state();

    // FETCH with delayed ack
    mem[16'd0] = 16'h1234;
    do_cmd(3'd0, 3'd0, 0, 0, 0, 16'd0, 3);
    chk("fetch_ir", ir, 16'h1234);
    chk("fetch_pc", pc_dbg, 16'd1);

    // R1=5; R2 = R1 + (-5)
    do_cmd(3'd1, 3'b100, 1, 0, 0, 16'd5, 0);
    do_cmd(3'd1, 3'b101, 2, 1, 0, 16'hFFFB, 0);
    rf_dbg_addr = 3'd2; #1;
    chk("add_zero", rf_dbg_data, 16'd0);
    chk("add_cc", cc, 3'b010);

    // branch masks against cc=P
    do_cmd(3'd1, 3'b100, 3, 0, 0, 16'd1, 0);
    do_cmd(3'd6, 3'b110, 0, 0, 0, 16'd4, 0);
    chk("br_not_taken", pc_dbg, 16'd1);
    do_cmd(3'd6, 3'b001, 0, 0, 0, 16'd4, 0);
    chk("br_taken", pc_dbg, 16'd5);

    // jump with link through R7 itself
    do_cmd(3'd1, 3'b100, 7, 0, 0, 16'h0033, 0);
    do_cmd(3'd7, 3'b001, 0, 7, 0, 16'd0, 0);
    chk("jmp_pc", pc_dbg, 16'h0033);
    rf_dbg_addr = 3'd7; #1;
    chk("jmp_link", rf_dbg_data, 16'd5);

    // PC=10 then indirect load (or illegal command without indirection)
    do_cmd(3'd1, 3'b100, 4, 0, 0, 16'd10, 0);
    do_cmd(3'd7, 3'b000, 0, 4, 0, 16'd0, 0);
    mem[16'd12] = 16'd40;
    mem[16'd40] = 16'h8001;
    do_cmd(3'd4, 3'd0, 5, 0, 0, 16'd2, 1);
    if (IND) begin
      rf_dbg_addr = 3'd5; #1;
      chk("ldi_val", rf_dbg_data, 16'h8001);
      chk("ldi_cc", cc, 3'b100);
    end
    do_cmd(3'd5, 3'd0, 0, 0, 1, 16'd2, 2);

    // PC wrap on fetch
    do_cmd(3'd1, 3'b100, 6, 0, 0, 16'hFFFF, 0);
    do_cmd(3'd7, 3'b000, 0, 6, 0, 16'd0, 0);
    do_cmd(3'd0, 3'd0, 0, 0, 0, 16'd0, 1);
    chk("pc_wrap", pc_dbg, 16'd0);

    // reset in the middle of an access; late ack must be ignored
    cmd_valid = 1'b1; cmd_op = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_req1", mem_req, 1);
    @(negedge clk);
    chk("mid_req2", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_req", mem_req, 0);
    rst = 1'b0;
    model_reset();
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_done", done, 0);
    chk("late_ack_req", mem_req, 0);
    check_state();

    // randomized commands against the model
    for (int n = 0; n < 300; n++) begin
      do_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             16'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
